// File: rtl/exu_alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: default widths, ALU
// operation codes, FSM state encoding and iterative shifter modes.
package exu_alu_mc_pkg;

  localparam int CFG_ISA_WIDTH       = 32;
  localparam int CFG_ALU_FUNCT_WIDTH = 4;
  // Shift amount is always taken from alu_b[4:0].
  localparam int SHAMT_WIDTH         = 5;

  typedef enum logic [3:0] {
    ALU_ADD       = 4'd0,
    ALU_SUB       = 4'd1,
    ALU_AND       = 4'd2,
    ALU_OR        = 4'd3,
    ALU_XOR       = 4'd4,
    ALU_EQ        = 4'd5,
    ALU_NEQ       = 4'd6,
    ALU_LESS_U    = 4'd7,
    ALU_LESS_S    = 4'd8,
    ALU_SHIFT_L_L = 4'd9,
    ALU_SHIFT_R_L = 4'd10,
    ALU_SHIFT_R_A = 4'd11,
    ALU_NO_FUNCT  = 4'd15
  } alu_funct_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/exu_alu_shifter.sv
// Iterative one-bit-per-cycle shifter: shift register plus down counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            capture load_value / load_shamt / load_mode
//   shift_en        perform one shift step while the counter is non-zero
//   load_value      operand to shift
//   load_shamt      number of steps to perform
//   load_mode       logical left, logical right or arithmetic right
//   count           remaining steps
//   step_value      value the register takes on the next step; the owner
//                   captures it on the final step
module exu_alu_shifter
  import exu_alu_mc_pkg::*;
#(
  parameter int WIDTH = CFG_ISA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       load_value,
  input  logic [SHAMT_WIDTH-1:0] load_shamt,
  input  shift_mode_e            load_mode,
  output logic [SHAMT_WIDTH-1:0] count,
  output logic [WIDTH-1:0]       step_value
);

  logic [WIDTH-1:0]       sreg_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  shift_mode_e            mode_reg;

  // For arithmetic right shifts the MSB never changes, so replicating
  // the current MSB keeps the original sign bit.
  always_comb begin
    step_value = sreg_reg;
    case (mode_reg)
      SH_LL:   step_value = {sreg_reg[WIDTH-2:0], 1'b0};
      SH_RL:   step_value = {1'b0, sreg_reg[WIDTH-1:1]};
      SH_RA:   step_value = {sreg_reg[WIDTH-1], sreg_reg[WIDTH-1:1]};
      default: step_value = sreg_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= SH_LL;
    end else if (load) begin
      sreg_reg  <= load_value;
      count_reg <= load_shamt;
      mode_reg  <= load_mode;
    end else if (shift_en && count_reg != '0) begin
      sreg_reg  <= step_value;
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/exu_alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on input and output.
// Single-cycle ops go IDLE->DONE; shifts go through an iterative shifter
// (IDLE->SHIFT->DONE) unless EXU_ALU_BARREL_SHIFT_EN is defined, in which
// case shifts are combinational and SHIFT is never entered.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      operation handshake (ready only in IDLE)
//   alu_a, alu_b, alu_funct  operands and operation code
//   out_valid / out_ready    result handshake (valid only in DONE)
//   alu_result               registered result, held outside DONE entry
module exu_alu_mc
  import exu_alu_mc_pkg::*;
#(
  parameter int ISA_WIDTH       = CFG_ISA_WIDTH,
  parameter int ALU_FUNCT_WIDTH = CFG_ALU_FUNCT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISA_WIDTH-1:0]       alu_a,
  input  logic [ISA_WIDTH-1:0]       alu_b,
  input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISA_WIDTH-1:0]       alu_result
);

  alu_state_e             state_reg, state_next;
  logic [ISA_WIDTH-1:0]   result_reg, result_next;
  logic [ISA_WIDTH-1:0]   op_result;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt = alu_b[SHAMT_WIDTH-1:0];

`ifdef EXU_ALU_BARREL_SHIFT_EN
  // Combinational result for every operation, shifts included.
  always_comb begin
    op_result = '0;
    case (alu_funct)
      ALU_ADD:       op_result = alu_a + alu_b;
      ALU_SUB:       op_result = alu_a - alu_b;
      ALU_AND:       op_result = alu_a & alu_b;
      ALU_OR:        op_result = alu_a | alu_b;
      ALU_XOR:       op_result = alu_a ^ alu_b;
      ALU_EQ:        op_result = ISA_WIDTH'(alu_a == alu_b);
      ALU_NEQ:       op_result = ISA_WIDTH'(alu_a != alu_b);
      ALU_LESS_U:    op_result = ISA_WIDTH'(alu_a < alu_b);
      ALU_LESS_S:    op_result = ISA_WIDTH'($signed(alu_a) < $signed(alu_b));
      ALU_SHIFT_L_L: op_result = alu_a << shamt;
      ALU_SHIFT_R_L: op_result = alu_a >> shamt;
      ALU_SHIFT_R_A: op_result = $unsigned($signed(alu_a) >>> shamt);
      default:       op_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next  = DONE;
          result_next = op_result;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
`else
  logic                   op_is_shift;
  shift_mode_e            op_mode;
  logic                   shift_load;
  logic                   shift_en;
  logic [SHAMT_WIDTH-1:0] shift_count;
  logic [ISA_WIDTH-1:0]   shift_step;

  // Shift ops yield alu_a here: that is the correct result for a zero
  // shift amount, the only case in which op_result is used for them.
  always_comb begin
    op_result   = '0;
    op_is_shift = 1'b0;
    op_mode     = SH_LL;
    case (alu_funct)
      ALU_ADD:       op_result = alu_a + alu_b;
      ALU_SUB:       op_result = alu_a - alu_b;
      ALU_AND:       op_result = alu_a & alu_b;
      ALU_OR:        op_result = alu_a | alu_b;
      ALU_XOR:       op_result = alu_a ^ alu_b;
      ALU_EQ:        op_result = ISA_WIDTH'(alu_a == alu_b);
      ALU_NEQ:       op_result = ISA_WIDTH'(alu_a != alu_b);
      ALU_LESS_U:    op_result = ISA_WIDTH'(alu_a < alu_b);
      ALU_LESS_S:    op_result = ISA_WIDTH'($signed(alu_a) < $signed(alu_b));
      ALU_SHIFT_L_L: begin op_result = alu_a; op_is_shift = 1'b1; op_mode = SH_LL; end
      ALU_SHIFT_R_L: begin op_result = alu_a; op_is_shift = 1'b1; op_mode = SH_RL; end
      ALU_SHIFT_R_A: begin op_result = alu_a; op_is_shift = 1'b1; op_mode = SH_RA; end
      default:       op_result = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    shift_load  = 1'b0;
    shift_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (op_is_shift && shamt != '0) begin
            shift_load = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next  = DONE;
            result_next = op_result;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // Final step: take the shifted value directly so DONE is entered
        // on the same edge the counter reaches zero.
        if (shift_count == SHAMT_WIDTH'(1)) begin
          state_next  = DONE;
          result_next = shift_step;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  exu_alu_shifter #(
    .WIDTH(ISA_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (shift_load),
    .shift_en  (shift_en),
    .load_value(alu_a),
    .load_shamt(shamt),
    .load_mode (op_mode),
    .count     (shift_count),
    .step_value(shift_step)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign alu_result = result_reg;

endmodule

// File: tb/tb_exu_alu_mc.sv
// Self-checking bench for exu_alu_mc: table of vectors plus hand-written
// sequences for back-pressure, input blocking and mid-shift reset.
module tb_exu_alu_mc;
  import exu_alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic [3:0]  alu_funct = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_result;

  always #5 clk = ~clk;

  exu_alu_mc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_funct (alu_funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] result;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] f, input logic [31:0] b);
`ifdef EXU_ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (f == ALU_SHIFT_L_L || f == ALU_SHIFT_R_L || f == ALU_SHIFT_R_A)
      return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Issue one op, optionally keep in_valid high with junk operands while
  // busy, then measure latency from the accepting edge to out_valid.
  task automatic run_op(input string name, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input bit junk);
    int   waited;
    int   cycles;
    exp_t e;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    alu_funct = f;
    alu_a     = a;
    alu_b     = b;
    in_valid  = 1'b1;
    sb_q.push_back('{res, exp_latency(f, b)});
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      alu_funct = ALU_ADD;
      alu_a     = $urandom;
      alu_b     = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    cycles = 1;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(cycles), 32'(e.lat));
    check({name, "_result"}, alu_result, e.result);
    $display("op %-12s funct=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d",
             name, f, a, b, alu_result, cycles);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    exp_t e;

    vecs[0]  = '{"add_wrap",   ALU_ADD,       32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{"sub_wrap",   ALU_SUB,       32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{"and",        ALU_AND,       32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[3]  = '{"or",         ALU_OR,        32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
    vecs[4]  = '{"xor",        ALU_XOR,       32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[5]  = '{"eq_true",    ALU_EQ,        32'h0000_0005, 32'h0000_0005, 32'h0000_0001};
    vecs[6]  = '{"neq_false",  ALU_NEQ,       32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
    vecs[7]  = '{"less_u",     ALU_LESS_U,    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{"less_s",     ALU_LESS_S,    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{"less_s_neg", ALU_LESS_S,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[10] = '{"no_funct",   ALU_NO_FUNCT,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
    vecs[11] = '{"undef_12",   4'd12,         32'h1234_5678, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{"sra_4",      ALU_SHIFT_R_A, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[13] = '{"sll_0",      ALU_SHIFT_L_L, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
    vecs[14] = '{"sll_31",     ALU_SHIFT_L_L, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[15] = '{"srl_31",     ALU_SHIFT_R_L, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    vecs[16] = '{"sra_pos_3",  ALU_SHIFT_R_A, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000};
    vecs[17] = '{"sll_hi_b",   ALU_SHIFT_L_L, 32'h0000_0003, 32'h0000_0022, 32'h0000_000C};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", alu_result, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].result, 1'b0);

    // Inputs held valid with junk while the shift is in progress.
    run_op("srl_blocked", ALU_SHIFT_R_L, 32'h0000_00F0, 32'h0000_0004, 32'h0000_000F, 1'b1);

    // Back-pressure: result and flags held in DONE, new request ignored.
    out_ready = 1'b0;
    alu_funct = ALU_ADD;
    alu_a     = 32'd7;
    alu_b     = 32'd8;
    in_valid  = 1'b1;
    sb_q.push_back('{32'd15, 1});
    @(posedge clk);
    @(negedge clk);
    alu_funct = ALU_XOR;
    alu_a     = 32'h1;
    alu_b     = 32'h2;
    e = sb_q.pop_front();
    check("bp_first_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", alu_result, e.result);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      $display("bp cycle=%0d out_valid=%0b result=0x%08h in_ready=%0b",
               c, out_valid, alu_result, in_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_result_kept", alu_result, 32'd15);
    @(negedge clk);
    check("bp_no_stale_accept", 32'(out_valid), 32'd0);

    // Reset asserted in the middle of a long shift.
    alu_funct = ALU_SHIFT_L_L;
    alu_a     = 32'h5;
    alu_b     = 32'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", alu_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("rst_mid_abandoned", 32'(seen), 32'd0);
    $display("rst_mid shift abandoned, out_valid cycles seen=%0d", seen);
    run_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
